// File: rtl/ds_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : ds_dac_multi
//  Description : Multi-channel delta-sigma DAC modulator. Each channel turns
//                an unsigned offset-binary sample stream into a 1-bit density
//                stream using a first- or second-order loop. The loop rate is
//                set by an internal divider. Input frames arrive over a
//                valid/ready handshake through a one-deep staging buffer.
//  Revision    : 1.0 - initial release (successor of ds_dac_sl)
// ============================================================================
module ds_dac_multi #(
    parameter int CH      = 2,
    parameter int DIN_W   = 16,
    parameter int MOD_DIV = 1
) (
    input  logic                  clk50m,
    input  logic                  rst,
    input  logic                  order2,
    input  logic                  mute,
    input  logic [CH*DIN_W-1:0]   din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  underrun_clr,
    output logic [CH-1:0]         dout,
    output logic                  mod_tick,
    output logic                  underrun
);

    localparam int DIV_W = 16;
    localparam int IW    = DIN_W + 4;   // second-order integrator width

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(MOD_DIV - 1);
    localparam logic [DIN_W-1:0] c_mid      = {1'b1, {(DIN_W-1){1'b0}}};

    // Arithmetic is done two bits wider than the integrators so that the
    // unsaturated sums never wrap before being clamped.
    localparam logic signed [IW+1:0] c_mid_e   = $signed({{(IW+2-DIN_W){1'b0}}, c_mid});
    localparam logic signed [IW+1:0] c_sat_max = $signed({3'b000, {(IW-1){1'b1}}});
    localparam logic signed [IW+1:0] c_sat_min = $signed({3'b111, {(IW-1){1'b0}}});

    function automatic logic signed [IW-1:0] f_sat(input logic signed [IW+1:0] v);
        if (v > c_sat_max)
            f_sat = $signed(c_sat_max[IW-1:0]);
        else if (v < c_sat_min)
            f_sat = $signed(c_sat_min[IW-1:0]);
        else
            f_sat = $signed(v[IW-1:0]);
    endfunction

    logic [DIV_W-1:0]        r_div;
    logic                    r_rst_d;
    logic                    r_full;
    logic [CH*DIN_W-1:0]     r_stage;
    logic [CH*DIN_W-1:0]     r_active;
    logic                    r_underrun;
    logic                    r_order;
    logic                    w_tick;
    logic                    w_accept;
    logic                    w_mode_chg;

    // Tick is suppressed in the first cycle out of reset so that din_ready
    // and the divider both start from a clean, idle state.
    assign w_tick     = (r_div == c_div_last) && !r_rst_d;
    assign din_ready  = !r_full && !r_rst_d;
    assign w_accept   = din_valid && din_ready;
    assign w_mode_chg = w_tick && (order2 != r_order);

    assign mod_tick   = w_tick;
    assign underrun   = r_underrun;

    // Modulator rate divider: counts 0..MOD_DIV-1 and wraps.
    always_ff @(posedge clk50m) begin
        if (rst)
            r_div <= '0;
        else if (r_div == c_div_last)
            r_div <= '0;
        else
            r_div <= r_div + DIV_W'(1);
    end

    // Delayed reset flag: holds din_ready low while reset is in effect.
    always_ff @(posedge clk50m) begin
        r_rst_d <= rst;
    end

    // Staging buffer: filled by the handshake, drained into active on a tick.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_stage <= '0;
        end else if (w_accept) begin
            r_full  <= 1'b1;
            r_stage <= din;
        end else if (w_tick && r_full) begin
            r_full  <= 1'b0;
        end
    end

    // Active sample frame: retained across ticks that find staging empty.
    always_ff @(posedge clk50m) begin
        if (rst)
            r_active <= {CH{c_mid}};
        else if (w_tick && r_full)
            r_active <= r_stage;
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge clk50m) begin
        if (rst)
            r_underrun <= 1'b0;
        else if (w_tick && !r_full)
            r_underrun <= 1'b1;
        else if (underrun_clr)
            r_underrun <= 1'b0;
    end

    // Stored loop order, only allowed to change on a tick.
    always_ff @(posedge clk50m) begin
        if (rst)
            r_order <= order2;
        else if (w_tick)
            r_order <= order2;
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [DIN_W-1:0]      w_x;
        logic [DIN_W:0]        w_sum1;
        logic signed [IW+1:0]  w_s;
        logic signed [IW+1:0]  w_fb;
        logic signed [IW+1:0]  w_i1_raw;
        logic signed [IW-1:0]  w_i1_new;
        logic signed [IW+1:0]  w_i2_raw;
        logic signed [IW-1:0]  w_i2_new;
        // The first-order carry bit lives in r_dout, so only the lower
        // DIN_W accumulator bits need storage.
        logic [DIN_W-1:0]      r_acc;
        logic signed [IW-1:0]  r_i1;
        logic signed [IW-1:0]  r_i2;
        logic                  r_dout;

        assign w_x      = mute ? c_mid : r_active[k*DIN_W +: DIN_W];
        assign w_sum1   = {1'b0, r_acc} + {1'b0, w_x};
        assign w_s      = $signed({{(IW+2-DIN_W){1'b0}}, w_x}) - c_mid_e;
        assign w_fb     = r_dout ? c_mid_e : -c_mid_e;
        assign w_i1_raw = $signed({{2{r_i1[IW-1]}}, r_i1}) + w_s - w_fb;
        assign w_i1_new = f_sat(w_i1_raw);
        assign w_i2_raw = $signed({{2{r_i2[IW-1]}}, r_i2})
                        + $signed({{2{w_i1_new[IW-1]}}, w_i1_new}) - w_fb;
        assign w_i2_new = f_sat(w_i2_raw);

        assign dout[k]  = r_dout;

        // Per-channel loop update; a mode change flushes all loop state.
        always_ff @(posedge clk50m) begin
            if (rst || w_mode_chg) begin
                r_acc  <= '0;
                r_i1   <= '0;
                r_i2   <= '0;
                r_dout <= 1'b0;
            end else if (w_tick) begin
                if (r_order) begin
                    r_i1   <= w_i1_new;
                    r_i2   <= w_i2_new;
                    r_dout <= ~w_i2_new[IW-1];
                end else begin
                    r_acc  <= w_sum1[DIN_W-1:0];
                    r_dout <= w_sum1[DIN_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ds_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ds_dac_multi
//  Description : Self-checking bench for ds_dac_multi. Instance A runs with
//                MOD_DIV=1 (bitstream patterns and densities), instance B
//                with MOD_DIV=4 (divider, handshake, underrun, latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ds_dac_multi;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance A (MOD_DIV = 1)
    logic        rst_a, order2_a, mute_a, valid_a, clr_a;
    logic [31:0] din_a;
    logic        ready_a, tick_a, underrun_a;
    logic [1:0]  dout_a;

    // instance B (MOD_DIV = 4)
    logic        rst_b, order2_b, mute_b, valid_b, clr_b;
    logic [31:0] din_b;
    logic        ready_b, tick_b, underrun_b;
    logic [1:0]  dout_b;

    ds_dac_multi #(.CH(2), .DIN_W(16), .MOD_DIV(1)) u_dut_a (
        .clk50m(clk), .rst(rst_a), .order2(order2_a), .mute(mute_a),
        .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .underrun_clr(clr_a), .dout(dout_a), .mod_tick(tick_a),
        .underrun(underrun_a)
    );

    ds_dac_multi #(.CH(2), .DIN_W(16), .MOD_DIV(4)) u_dut_b (
        .clk50m(clk), .rst(rst_b), .order2(order2_b), .mute(mute_b),
        .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .underrun_clr(clr_b), .dout(dout_b), .mod_tick(tick_b),
        .underrun(underrun_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] qa[$];
    logic [1:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count ones on each channel of A over n ticks (one tick per cycle).
    task automatic count_a(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        repeat (n) begin
            step();
            c0 += int'(dout_a[0]);
            c1 += int'(dout_a[1]);
        end
    endtask

    // Scoreboard monitors: after each modulator tick, the registered dout
    // is compared against the next queued expectation.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (tick_a === 1'b1) begin
                @(posedge clk);
                #1;
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("sb_a_dout", 32'(dout_a), 32'(e));
                end
            end
        end
    end

    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (tick_b === 1'b1) begin
                @(posedge clk);
                #1;
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("sb_b_dout", 32'(dout_b), 32'(e));
                end
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        rst_a = 1'b1; order2_a = 1'b0; mute_a = 1'b0; valid_a = 1'b0; clr_a = 1'b0; din_a = '0;
        rst_b = 1'b1; order2_b = 1'b0; mute_b = 1'b0; valid_b = 1'b0; clr_b = 1'b0; din_b = '0;
        step();
        step();

        // ---------------- A: reset state and first-order patterns -------------
        rst_a   = 1'b0;
        valid_a = 1'b1;
        din_a   = {16'h4000, 16'h8000};
        chk("a_rst_dout",     32'(dout_a),     32'h0);
        chk("a_rst_tick",     32'(tick_a),     32'h0);
        chk("a_rst_underrun", 32'(underrun_a), 32'h0);
        chk("a_rst_ready",    32'(ready_a),    32'h0);
        step();
        chk("a_ready_after_rst", 32'(ready_a), 32'h1);
        chk("a_tick_every",      32'(tick_a),  32'h1);
        step();
        chk("a_ready_full",      32'(ready_a),    32'h0);
        chk("a_underrun_first",  32'(underrun_a), 32'h1);
        chk("a_dout_mid0",       32'(dout_a),     32'h0);
        step();
        chk("a_dout_mid1",       32'(dout_a),     32'h3);
        #1;
        // ch0 = 0x8000 -> 0,1,0,1 ; ch1 = 0x4000 -> 0,0,0,1
        repeat (2) begin
            qa.push_back(2'b00);
            qa.push_back(2'b01);
            qa.push_back(2'b00);
            qa.push_back(2'b11);
        end
        repeat (9) step();

        // ---------------- A: first-order extremes -------------------------------
        din_a = {16'h0000, 16'h0000};
        repeat (4) step();
        count_a(1024, c0, c1);
        chk("a_zero_ch0", 32'(c0), 32'd0);
        chk("a_zero_ch1", 32'(c1), 32'd0);

        din_a = {16'hFFFF, 16'hFFFF};
        repeat (4) step();
        order2_a = 1'b1;
        step();
        chk("a_modechg_dout0", 32'(dout_a), 32'h0);
        order2_a = 1'b0;
        step();
        chk("a_modechg_dout1", 32'(dout_a), 32'h0);
        // from a zeroed accumulator only the first of 4096 ticks is 0
        count_a(4096, c0, c1);
        chk("a_full_ch0", 32'(c0), 32'd4095);
        chk("a_full_ch1", 32'(c1), 32'd4095);

        // ---------------- A: second order and mode toggle -----------------------
        din_a = {16'h8000, 16'h8000};
        repeat (4) step();
        order2_a = 1'b1;
        step();
        chk("a_toggle_dout", 32'(dout_a), 32'h0);
        count_a(256, c0, c1);
        chk_range("a_o2_half_ch0", c0, 127, 129);
        chk_range("a_o2_half_ch1", c1, 127, 129);

        din_a = {16'hC000, 16'hC000};
        repeat (4) step();
        order2_a = 1'b0;
        step();
        order2_a = 1'b1;
        step();
        chk("a_toggle2_dout", 32'(dout_a), 32'h0);
        count_a(256, c0, c1);
        chk_range("a_o2_3q_ch0", c0, 191, 193);
        chk_range("a_o2_3q_ch1", c1, 191, 193);

        // ---------------- A: mute -------------------------------------------------
        din_a    = {16'hFFFF, 16'hFFFF};
        order2_a = 1'b0;
        mute_a   = 1'b1;
        repeat (2) step();
        count_a(256, c0, c1);
        chk("a_mute_ch0", 32'(c0), 32'd128);
        chk("a_mute_ch1", 32'(c1), 32'd128);
        mute_a = 1'b0;

        // ---------------- A: mid-stream reset ------------------------------------
        rst_a = 1'b1;
        step();
        chk("a_mrst_dout",     32'(dout_a),     32'h0);
        chk("a_mrst_tick",     32'(tick_a),     32'h0);
        chk("a_mrst_underrun", 32'(underrun_a), 32'h0);
        chk("a_mrst_ready",    32'(ready_a),    32'h0);
        rst_a = 1'b0;
        step();
        chk("a_mrst_ready_after", 32'(ready_a), 32'h1);
        valid_a = 1'b0;

        // ---------------- B: divider, handshake, underrun ------------------------
        step();                       // last reset edge of B (e0)
        rst_b   = 1'b0;
        valid_b = 1'b1;
        din_b   = {16'hFFFF, 16'h0000};
        // dout after ticks at e4,e8,...,e28 ({ch1,ch0})
        qb.push_back(2'b00);
        qb.push_back(2'b10);
        qb.push_back(2'b10);
        qb.push_back(2'b10);
        qb.push_back(2'b10);
        qb.push_back(2'b10);
        qb.push_back(2'b01);
        chk("b_rst_ready", 32'(ready_b), 32'h0);
        chk("b_rst_tick",  32'(tick_b),  32'h0);
        step();                       // e1
        chk("b_ready_e1", 32'(ready_b), 32'h1);
        chk("b_tick_e1",  32'(tick_b),  32'h0);
        step();                       // e2: accept
        valid_b = 1'b0;
        chk("b_ready_e2", 32'(ready_b), 32'h0);
        chk("b_tick_e2",  32'(tick_b),  32'h0);
        step();                       // e3
        chk("b_ready_e3", 32'(ready_b), 32'h0);
        chk("b_tick_e3",  32'(tick_b),  32'h1);
        step();                       // e4: tick moves staging to active
        chk("b_ready_e4",    32'(ready_b),    32'h1);
        chk("b_tick_e4",     32'(tick_b),     32'h0);
        chk("b_underrun_e4", 32'(underrun_b), 32'h0);
        step();
        step();
        step();                       // e7
        chk("b_tick_e7", 32'(tick_b), 32'h1);
        step();                       // e8: tick with staging empty
        chk("b_underrun_e8", 32'(underrun_b), 32'h1);
        repeat (4) step();            // e12
        clr_b = 1'b1;
        step();                       // e13
        chk("b_underrun_clr", 32'(underrun_b), 32'h0);
        clr_b = 1'b0;
        step();
        step();                       // e15
        clr_b = 1'b1;
        step();                       // e16: clear and set coincide
        chk("b_underrun_setwins", 32'(underrun_b), 32'h1);
        clr_b = 1'b0;
        repeat (3) step();            // e19
        valid_b = 1'b1;
        din_b   = {16'h0000, 16'hFFFF};
        step();                       // e20: accept coincides with tick
        valid_b = 1'b0;
        chk("b_ready_e20",    32'(ready_b),    32'h0);
        chk("b_underrun_e20", 32'(underrun_b), 32'h1);
        repeat (4) step();            // e24
        chk("b_ready_e24", 32'(ready_b), 32'h1);
        repeat (6) step();            // e30

        chk("sb_a_drained", 32'(qa.size()), 32'd0);
        chk("sb_b_drained", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ds_dac_multi.md
Name: ds_dac_multi

Overview:
- Parametrised multi-channel delta-sigma DAC modulator. It succeeds the single-channel fixed-order ds_dac_sl.
- Each channel converts an unsigned offset-binary sample stream into a 1-bit density stream, in first- or second-order mode.
- Modulator update rate comes from an internal divider. Input uses a valid/ready handshake with a one-deep staging buffer per block, plus mute and underrun reporting.
- Sits between the sample source (sine ROM / tone generator) and the GPIO/LED bitstream outputs.

Parameters:
- CH, 2, number of channels.
- DIN_W, 16, sample width per channel (unsigned offset binary; midscale = 2^(DIN_W-1)).
- MOD_DIV, 1, modulator update period in clk50m cycles (1 = every cycle; legal range 1..65535).

Ports:
- clk50m  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- order2  in  1  0 = first-order, 1 = second-order modulator (applies to all channels).
- mute  in  1  1 = all channels modulate midscale.
- din  in  CH*DIN_W  packed samples; channel k occupies bits [k*DIN_W +: DIN_W].
- din_valid  in  1  din holds a sample frame (all channels).
- din_ready  out  1  staging buffer empty; frame accepted when din_valid & din_ready.
- underrun_clr  in  1  clears underrun.
- dout  out  CH  delta-sigma bitstreams, registered.
- mod_tick  out  1  single-cycle pulse, high in the cycle the modulators update.
- underrun  out  1  sticky: a mod_tick occurred with the staging buffer empty.

Behaviour:
- Reset (rst=1 at clk50m edge):
  - divider = 0, mod_tick = 0, dout = 0, underrun = 0.
  - Staging empty; din_ready = 0 during reset, 1 in the first cycle after.
  - Active samples = midscale; all accumulators/integrators = 0; stored order = order2.
- Divider:
  - Counts 0..MOD_DIV-1.
  - mod_tick = 1 in the cycle the count equals MOD_DIV-1 (every cycle when MOD_DIV=1). The count then wraps to 0.
- Input buffering:
  - Accept on din_valid & din_ready; staging becomes full and din_ready drops the next cycle.
  - On mod_tick with staging full: staging moves to the active registers and staging empties.
  - Accept and tick in the same cycle with staging empty: the new frame goes to staging only. It reaches active on the following tick.
  - On mod_tick with staging empty: active is retained and underrun is set.
  - underrun_clr clears underrun. A simultaneous set wins.
- Effective input:
  - x_k = midscale when mute = 1, else active_k.
  - Mute acts at the next mod_tick. Staging and handshake continue normally while muted.
- First-order (per channel, on mod_tick):
  - acc is DIN_W+1 bits.
  - sum = acc[DIN_W-1:0] + x_k; acc <= sum; dout_k <= sum[DIN_W].
  - Long-run density of 1s = x_k / 2^DIN_W exactly.
- Second-order (per channel, on mod_tick):
  - Signed integrators i1, i2 of DIN_W+4 bits. s = x_k - midscale (signed, DIN_W+1 bits).
  - fb = +midscale if dout_k = 1, else -midscale.
  - i1 <= sat(i1 + s - fb); i2 <= sat(i2 + i1_new - fb); dout_k <= (i2_new >= 0).
  - sat clamps to the signed range of DIN_W+4 bits; there is no wrap-around.
- Mode change:
  - If order2 differs from the stored order at a mod_tick, that tick clears acc/i1/i2 to 0, updates the stored order, and drives dout = 0.
  - Normal modulation resumes at the next tick.
- Latency:
  - A sample accepted at cycle t (staging previously empty, no tick at t) becomes active at the first mod_tick after t.
  - It affects dout at the second mod_tick after t; dout changes only on mod_tick cycles.
- Mid-operation reset: rst dominates all other inputs in that cycle. Any frame presented during rst is not accepted.

Test Plan:
- CH=2, DIN_W=16, MOD_DIV=1, order2=0; load din={0x4000,0x8000}, valid held.
  - Once active: dout[0] runs 0,1,0,1…
  - dout[1] has exactly one 1 per 4 ticks.
- First-order extremes: din=0x0000 → dout all 0 over 1024 ticks. din=0xFFFF → exactly 65535 ones per 65536 ticks.
- Handshake/underrun, MOD_DIV=4:
  - mod_tick every 4th cycle; din_ready low from accept until the cycle after the next tick.
  - Withhold valid for 8 cycles → underrun=1 and active retained.
  - underrun_clr → 0, unless a tick with empty staging coincides.
- Second-order, din=0x8000 steady → density 0.5 ± 1/256 over 256 ticks. din=0xC000 → 0.75 ± 1/256. No integrator reaches saturation.
- Mode toggle mid-stream (order2 0→1) → the next tick drives dout=0 with zeroed state; density converges to the expected value.
- mute=1 with din=0xFFFF → density 0.5. Assert rst for 1 cycle mid-stream → all outputs at reset values next cycle; din_ready=1 one cycle after rst falls.
